// File: rtl/serdesphy_ana_digital_pfd_if.sv
// serdesphy_ana_digital_pfd_if
//    Bundles the PFD's control, sampled clock inputs and detector outputs.
//    slave  : PFD side (consumes enable/ref_in/fb_in, drives results)
//    master : PLL control side (drives enable/ref_in/fb_in, observes results)
//
//    enable      synchronous enable; low idles the detector and clears state
//    ref_in      reference clock, asynchronous to clk
//    fb_in       divided feedback clock, asynchronous to clk
//    up_pulse    charge-pump UP
//    down_pulse  charge-pump DOWN
//    phase_err   signed error of the last comparison, + when ref leads
//    err_valid   one-cycle strobe when phase_err updates
//    cycle_slip  one-cycle strobe on a second same-side edge before closure
//    locked      hysteretic lock indication
interface serdesphy_ana_digital_pfd_if #(
   parameter int ERR_W = 8
);
   logic                    enable;
   logic                    ref_in;
   logic                    fb_in;
   logic                    up_pulse;
   logic                    down_pulse;
   logic signed [ERR_W-1:0] phase_err;
   logic                    err_valid;
   logic                    cycle_slip;
   logic                    locked;

   modport slave (
      input  enable, ref_in, fb_in,
      output up_pulse, down_pulse, phase_err, err_valid, cycle_slip, locked
   );

   modport master (
      output enable, ref_in, fb_in,
      input  up_pulse, down_pulse, phase_err, err_valid, cycle_slip, locked
   );
endinterface

// File: rtl/serdesphy_ana_digital_pfd.sv
// serdesphy_ana_digital_pfd
//    Digital phase-frequency detector with lock detection for the SerDes PLL.
//    ref_in and fb_in are synchronised into clk, rising edges are detected,
//    and a tri-state UP/DN machine measures the edge separation in clk cycles.
//
//    clk    sampling clock, faster than ref/fb
//    rst_n  asynchronous active-low reset
//    pfd    serdesphy_ana_digital_pfd_if.slave (enable, ref_in, fb_in in;
//           up_pulse, down_pulse, phase_err, err_valid, cycle_slip, locked out)
//
//    state | meaning
//    IDLE  | no comparison open
//    UP    | ref edge seen, waiting for fb edge (ref leads)
//    DN    | fb edge seen, waiting for ref edge (fb leads)
module serdesphy_ana_digital_pfd #(
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_CNT    = 16,
   parameter int UNLOCK_CNT  = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   serdesphy_ana_digital_pfd_if.slave  pfd
);
   localparam int CNT_MAX = (2 ** (ERR_W - 1)) - 1;
   localparam int TOL_C   = (LOCK_TOL > CNT_MAX) ? CNT_MAX : LOCK_TOL;
   localparam int GW      = $clog2(LOCK_CNT + 1);
   localparam int BW      = $clog2(UNLOCK_CNT + 1);

   localparam logic [ERR_W-2:0] TOL_V    = (ERR_W - 1)'(TOL_C);
   localparam logic [ERR_W-2:0] ONE_V    = (ERR_W - 1)'(1);
   localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);
   localparam logic [BW-1:0]    BAD_MAX  = BW'(UNLOCK_CNT);

   typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DN} state_t;

   logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
   logic                   ref_hist, fb_hist;
   logic                   e_ref, e_fb;

   state_t                  state, state_nxt;
   logic [ERR_W-2:0]        err_cnt, err_cnt_nxt, err_inc;
   logic                    close, close_neg, slip;
   logic signed [ERR_W-1:0] mag, err_new;
   logic                    good_cmp;

   logic                    up_q, dn_q, err_valid_q, slip_q, locked_q;
   logic signed [ERR_W-1:0] phase_err_q;
   logic [GW-1:0]           good_cnt;
   logic [BW-1:0]           bad_cnt;

   // Synchronisers run regardless of enable so re-enabling never sees a
   // stale level as a fresh edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sync <= '0;
         fb_sync  <= '0;
         ref_hist <= 1'b0;
         fb_hist  <= 1'b0;
      end else begin
         ref_sync <= {ref_sync[SYNC_STAGES-2:0], pfd.ref_in};
         fb_sync  <= {fb_sync[SYNC_STAGES-2:0], pfd.fb_in};
         ref_hist <= ref_sync[SYNC_STAGES-1];
         fb_hist  <= fb_sync[SYNC_STAGES-1];
      end
   end

   assign e_ref = ref_sync[SYNC_STAGES-1] & ~ref_hist;
   assign e_fb  = fb_sync[SYNC_STAGES-1] & ~fb_hist;

   assign err_inc  = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
   assign mag      = {1'b0, err_cnt};
   assign err_new  = close_neg ? -mag : mag;
   assign good_cmp = (err_cnt <= TOL_V);

   always_comb begin
      state_nxt   = state;
      err_cnt_nxt = err_cnt;
      close       = 1'b0;
      close_neg   = 1'b0;
      slip        = 1'b0;
      case (state)
         ST_IDLE: begin
            // err_cnt is 0 here, so a coincident pair closes with zero error
            if (e_ref && e_fb) begin
               close = 1'b1;
            end else if (e_ref) begin
               state_nxt   = ST_UP;
               err_cnt_nxt = ONE_V;
            end else if (e_fb) begin
               state_nxt   = ST_DN;
               err_cnt_nxt = ONE_V;
            end
         end
         ST_UP: begin
            // the closing edge wins over a coincident same-side edge
            if (e_fb) begin
               close       = 1'b1;
               state_nxt   = ST_IDLE;
               err_cnt_nxt = '0;
            end else begin
               err_cnt_nxt = err_inc;
               slip        = e_ref;
            end
         end
         ST_DN: begin
            if (e_ref) begin
               close       = 1'b1;
               close_neg   = 1'b1;
               state_nxt   = ST_IDLE;
               err_cnt_nxt = '0;
            end else begin
               err_cnt_nxt = err_inc;
               slip        = e_fb;
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            err_cnt_nxt = '0;
         end
      endcase
      if (!pfd.enable) begin
         state_nxt   = ST_IDLE;
         err_cnt_nxt = '0;
         close       = 1'b0;
         close_neg   = 1'b0;
         slip        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         err_cnt     <= '0;
         up_q        <= 1'b0;
         dn_q        <= 1'b0;
         err_valid_q <= 1'b0;
         slip_q      <= 1'b0;
         phase_err_q <= '0;
         good_cnt    <= '0;
         bad_cnt     <= '0;
         locked_q    <= 1'b0;
      end else begin
         state       <= state_nxt;
         err_cnt     <= err_cnt_nxt;
         up_q        <= (state_nxt == ST_UP);
         dn_q        <= (state_nxt == ST_DN);
         err_valid_q <= close;
         slip_q      <= slip;
         if (!pfd.enable) begin
            phase_err_q <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked_q    <= 1'b0;
         end else begin
            if (close) begin
               phase_err_q <= err_new;
            end
            if (close && good_cmp) begin
               good_cnt <= (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
               bad_cnt  <= '0;
            end else if (close || slip) begin
               bad_cnt  <= (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + 1'b1;
               good_cnt <= '0;
            end
            // counters settle on the event edge; lock follows one cycle later
            if (good_cnt == GOOD_MAX) begin
               locked_q <= 1'b1;
            end else if (bad_cnt == BAD_MAX) begin
               locked_q <= 1'b0;
            end
         end
      end
   end

   assign pfd.up_pulse   = up_q;
   assign pfd.down_pulse = dn_q;
   assign pfd.phase_err  = phase_err_q;
   assign pfd.err_valid  = err_valid_q;
   assign pfd.cycle_slip = slip_q;
   assign pfd.locked     = locked_q;
endmodule

// File: doc/serdesphy_ana_digital_pfd.md
Name: serdesphy_ana_digital_pfd

Overview:
- Parametrised, single-clock-domain digital phase-frequency detector with lock detection for the SerDes PLL loop.
- Synchronises the asynchronous reference and feedback clocks into a fast sampling clock, then runs a tri-state UP/DN state machine.
- Reports a signed phase error in sample cycles per comparison, flags cycle slips, and asserts a hysteretic lock indication.
- Feeds the charge pump (up/dn) and the PLL control/status logic (phase_err, locked).

Parameters:
SYNC_STAGES, 2, synchroniser depth on ref_in and fb_in (min 2)
ERR_W, 8, width of signed phase_err; magnitude saturates at 2^(ERR_W-1)-1
LOCK_TOL, 2, max |phase_err| (sample cycles) counted as an in-lock comparison
LOCK_CNT, 16, consecutive good comparisons required to assert locked
UNLOCK_CNT, 4, consecutive bad comparisons required to deassert locked

Ports:
clk  input  1  sampling clock, faster than ref/fb
rst_n  input  1  asynchronous active-low reset
enable  input  1  synchronous enable; low forces idle and clears all state
ref_in  input  1  reference clock, asynchronous to clk
fb_in  input  1  feedback clock from divider, asynchronous to clk
up_pulse  output  1  charge-pump UP, registered
down_pulse  output  1  charge-pump DOWN, registered
phase_err  output  ERR_W  signed error of last comparison: + means ref leads
err_valid  output  1  one-cycle strobe when phase_err updates
cycle_slip  output  1  one-cycle strobe on a second same-side edge before closure
locked  output  1  lock indication

Behaviour:
- Reset: all outputs 0, state IDLE, synchronisers 0, counters 0.
- Sync and edge detection:
  - Each input passes through SYNC_STAGES flops, then a history flop.
  - The edge strobe (e_ref / e_fb) is sync_out & ~hist.
  - Both paths have identical latency, so relative timing is preserved.
- State machine (state, err_cnt):
  - IDLE:
    - e_ref & e_fb -> stay IDLE; comparison closes with error 0.
    - e_ref only -> UP, err_cnt=1.
    - e_fb only -> DN, err_cnt=1.
  - UP:
    - e_fb -> IDLE; comparison closes with +err_cnt. This applies even if e_ref fires in the same cycle.
    - e_ref without e_fb -> stay UP, cycle_slip=1 next cycle, err_cnt continues.
    - Otherwise err_cnt++.
  - DN: mirror of UP. e_ref closes with -err_cnt; e_fb without e_ref is a slip.
  - err_cnt saturates at 2^(ERR_W-1)-1 and never wraps.
- Outputs:
  - up_pulse = (state==UP) and down_pulse = (state==DN), both registered; never both 1.
  - On closure, phase_err loads the signed value and err_valid pulses for exactly 1 cycle after the closing edge strobe.
  - phase_err holds its value between closures.
- Lock detector, updated on each err_valid or cycle_slip:
  - good = err_valid & |phase_err_new| <= LOCK_TOL. Any slip is bad.
  - good: good_cnt++ (saturates at LOCK_CNT), bad_cnt=0.
  - bad: bad_cnt++ (saturates at UNLOCK_CNT), good_cnt=0.
  - locked sets the cycle after good_cnt reaches LOCK_CNT.
  - locked clears the cycle after bad_cnt reaches UNLOCK_CNT; otherwise it holds.
- enable low (synchronous):
  - state IDLE; up/down 0; err_cnt, good_cnt, bad_cnt 0; locked 0; phase_err 0; strobes 0.
  - Synchronisers keep running so no spurious edge appears on re-enable.
- Reset asserted mid-comparison: immediate return to reset values.

Test Plan:
- Equal-frequency, aligned: ref and fb period 20 clk, zero skew -> up/down never assert, phase_err=0 every 20 clk, locked rises after the 16th comparison.
- Ref leads by 5 clk: -> up_pulse high 5 cycles per period, phase_err=+5, locked stays 0; then reduce skew to 2 -> locked after 16 comparisons.
- Fb leads by 7 clk while locked: -> down_pulse 7 cycles, phase_err=-7, locked drops after the 4th bad comparison.
- Ref at 2x fb frequency: -> UP held across a second ref edge, cycle_slip pulses, phase_err magnitude grows; ERR_W=4 with a long gap -> phase_err saturates at +7.
- Simultaneous edges in IDLE and in UP state -> IDLE closure with 0, and UP closure with +count, respectively; no slip flagged.
- enable dropped mid-UP, then rst_n asserted mid-DN -> all outputs 0 the next cycle (enable) or immediately (reset); the first comparison after re-enable is correct.
